// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings, opcode field
// bounds and the default memory-wait limit.
package fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 11;
  localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: loads a target or increments by one, wrapping silently at
// the top of the address space. A load always beats an increment.
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory read per fetch request, latches the
// instruction word, and handles jumps that arrive while a read is outstanding.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   jump_addr,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic                ir_valid,
  output logic                busy,
  output logic [ADDR_W-1:0]   pc,
  output logic                fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_d, state_q;
  logic [CNT_W-1:0]  wait_d, wait_q;
  logic              pend_valid_d, pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_d, pend_addr_q;
  logic [DATA_W-1:0] ir_d, ir_q;
  logic              err_d, err_q;
  logic              pc_inc;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc_ld_addr;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    ir_d         = ir_q;
    err_d        = err_q;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    pc_ld_addr   = jump_addr;

    case (state_q)
      ST_IDLE: begin
        wait_d       = '0;
        pend_valid_d = 1'b0;
        pc_ld        = pc_load;
        if (fetch) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = jump_addr;
        end
        if (mem_ack) begin
          wait_d       = '0;
          pend_valid_d = 1'b0;
          // A jump seen during the read squashes the fetched word; a jump in
          // the acknowledging cycle itself is the newest target.
          if (pc_load || pend_valid_q) begin
            pc_ld      = 1'b1;
            pc_ld_addr = pc_load ? jump_addr : pend_addr_q;
            state_d    = ST_IDLE;
          end else begin
            ir_d    = mem_rdata;
            pc_inc  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          err_d        = 1'b1;
          wait_d       = '0;
          pend_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        pc_ld   = pc_load;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      ir_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      ir_q         <= ir_d;
      err_q        <= err_d;
    end
  end

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .inc       (pc_inc),
    .load      (pc_ld),
    .load_addr (pc_ld_addr),
    .pc        (pc)
  );

  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = pc;
  assign ir_valid  = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign ir        = ir_q;
  assign opcode    = ir_q[OPCODE_HI:OPCODE_LO];
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: each scenario task drives the block and
// compares outputs against hand-computed values one time unit after the edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch;
  logic        pc_load;
  logic [7:0]  jump_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic        ir_valid;
  logic        busy;
  logic [7:0]  pc;
  logic        fetch_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .pc_load   (pc_load),
    .jump_addr (jump_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .opcode    (opcode),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .pc        (pc),
    .fetch_err (fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch = 1'b0; pc_load = 1'b0; jump_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    vectors++; if ({mem_req, ir_valid, busy, fetch_err} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {mem_req, ir_valid, busy, fetch_err}); end
    vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h want 00", pc); end
    vectors++; if (ir !== 16'h0000) begin miscompares++; $display("FAIL reset_ir: got %h want 0000", ir); end
    rst = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  // pc=0, ack two cycles after mem_req first appears
  task automatic test_basic_fetch();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    vectors++; if ({mem_req, busy, ir_valid} !== 3'b110) begin miscompares++; $display("FAIL basic_req: got %b want 110", {mem_req, busy, ir_valid}); end
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL basic_addr: got %h want 00", mem_addr); end
    step();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL basic_wait_req: got %b want 1", mem_req); end
    step();
    mem_ack = 1'b1; mem_rdata = 16'h3A05;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    vectors++; if (ir !== 16'h3A05) begin miscompares++; $display("FAIL basic_ir: got %h want 3a05", ir); end
    vectors++; if (opcode !== 5'b00111) begin miscompares++; $display("FAIL basic_opcode: got %b want 00111", opcode); end
    vectors++; if ({ir_valid, busy, mem_req} !== 3'b110) begin miscompares++; $display("FAIL basic_done: got %b want 110", {ir_valid, busy, mem_req}); end
    vectors++; if (pc !== 8'h01) begin miscompares++; $display("FAIL basic_pc: got %h want 01", pc); end
    step();
    vectors++; if ({ir_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_pulse_end: got %b want 00", {ir_valid, busy}); end
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; jump_addr = 8'hFF;
    step();
    pc_load = 1'b0;
    vectors++; if (pc !== 8'hFF) begin miscompares++; $display("FAIL wrap_load: got %h want ff", pc); end
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    vectors++; if (mem_addr !== 8'hFF) begin miscompares++; $display("FAIL wrap_addr: got %h want ff", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h7800;
    step();
    mem_ack = 1'b0;
    vectors++; if (ir !== 16'h7800) begin miscompares++; $display("FAIL wrap_ir: got %h want 7800", ir); end
    vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL wrap_pc: got %h want 00", pc); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL wrap_err: got %b want 0", fetch_err); end
    step();
  endtask

  // ack with a stray data word outside REQ must change nothing
  task automatic test_ack_outside_req();
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step(); step();
    mem_ack = 1'b0;
    vectors++; if (ir !== 16'h7800) begin miscompares++; $display("FAIL stray_ack_ir: got %h want 7800", ir); end
    vectors++; if ({busy, ir_valid} !== 2'b00) begin miscompares++; $display("FAIL stray_ack_state: got %b want 00", {busy, ir_valid}); end
  endtask

  task automatic test_jump_in_req();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    pc_load = 1'b1; jump_addr = 8'h40;
    step();
    pc_load = 1'b0; jump_addr = 8'h00;
    vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL jump_pending_pc: got %h want 00", pc); end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    vectors++; if ({ir_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL jump_state: got %b want 00", {ir_valid, busy}); end
    vectors++; if (ir !== 16'h7800) begin miscompares++; $display("FAIL jump_ir: got %h want 7800", ir); end
    vectors++; if (pc !== 8'h40) begin miscompares++; $display("FAIL jump_pc: got %h want 40", pc); end
  endtask

  // second pc_load in the same read wins
  task automatic test_jump_overwrite();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    pc_load = 1'b1; jump_addr = 8'h20;
    step();
    jump_addr = 8'h30;
    step();
    pc_load = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0;
    vectors++; if (pc !== 8'h30) begin miscompares++; $display("FAIL overwrite_pc: got %h want 30", pc); end
    vectors++; if (ir !== 16'h7800) begin miscompares++; $display("FAIL overwrite_ir: got %h want 7800", ir); end
  endtask

  task automatic test_timeout();
    int n;
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    vectors++; if (n !== 15) begin miscompares++; $display("FAIL timeout_cycles: got %0d want 15", n); end
    vectors++; if ({fetch_err, busy} !== 2'b10) begin miscompares++; $display("FAIL timeout_flags: got %b want 10", {fetch_err, busy}); end
    vectors++; if (pc !== 8'h30) begin miscompares++; $display("FAIL timeout_pc: got %h want 30", pc); end
    vectors++; if (ir !== 16'h7800) begin miscompares++; $display("FAIL timeout_ir: got %h want 7800", ir); end
    step(); step();
    vectors++; if (fetch_err !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b want 1", fetch_err); end
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 1'b0;
    vectors++; if ({ir_valid, fetch_err} !== 2'b11) begin miscompares++; $display("FAIL after_timeout_done: got %b want 11", {ir_valid, fetch_err}); end
    vectors++; if (ir !== 16'h5A5A) begin miscompares++; $display("FAIL after_timeout_ir: got %h want 5a5a", ir); end
    vectors++; if (pc !== 8'h31) begin miscompares++; $display("FAIL after_timeout_pc: got %h want 31", pc); end
    step();
  endtask

  // fetch held high through REQ and DONE must not restart the FSM
  task automatic test_fetch_while_busy();
    fetch = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h0800;
    step();
    mem_ack = 1'b0;
    vectors++; if (opcode !== 5'b00001) begin miscompares++; $display("FAIL busy_opcode: got %b want 00001", opcode); end
    step();
    fetch = 1'b0;
    vectors++; if ({busy, mem_req} !== 2'b00) begin miscompares++; $display("FAIL busy_ignored: got %b want 00", {busy, mem_req}); end
    vectors++; if (pc !== 8'h32) begin miscompares++; $display("FAIL busy_pc: got %h want 32", pc); end
  endtask

  task automatic test_load_and_fetch();
    pc_load = 1'b1; jump_addr = 8'h10; fetch = 1'b1;
    step();
    pc_load = 1'b0; fetch = 1'b0;
    vectors++; if ({mem_req, mem_addr} !== {1'b1, 8'h10}) begin miscompares++; $display("FAIL loadfetch_addr: got %b/%h want 1/10", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'hC001;
    step();
    mem_ack = 1'b0;
    vectors++; if (pc !== 8'h11) begin miscompares++; $display("FAIL loadfetch_pc: got %h want 11", pc); end
    // jump in DONE overrides the increment
    pc_load = 1'b1; jump_addr = 8'h80;
    step();
    pc_load = 1'b0;
    vectors++; if ({pc, busy} !== {8'h80, 1'b0}) begin miscompares++; $display("FAIL done_load: got %h/%b want 80/0", pc, busy); end
  endtask

  task automatic test_async_reset();
    // make fetch_err sticky first so the reset has something to clear
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    repeat (16) step();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    vectors++; if ({mem_req, fetch_err} !== 2'b11) begin miscompares++; $display("FAIL areset_setup: got %b want 11", {mem_req, fetch_err}); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({mem_req, ir_valid, busy, fetch_err} !== 4'b0000) begin miscompares++; $display("FAIL areset_flags: got %b want 0000", {mem_req, ir_valid, busy, fetch_err}); end
    vectors++; if ({pc, ir} !== 24'h0) begin miscompares++; $display("FAIL areset_regs: got %h/%h want 00/0000", pc, ir); end
    step();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    vectors++; if ({busy, ir} !== {1'b0, 16'h0000}) begin miscompares++; $display("FAIL areset_idle: got %b/%h want 0/0000", busy, ir); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wrap();
    test_ack_outside_req();
    test_jump_in_req();
    test_jump_overwrite();
    test_timeout();
    test_fetch_while_busy();
    test_load_and_fetch();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
